// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
// State encoding, width limit and counter sizing helper.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_MAX = 32;

    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Purely combinational 1-bit full adder.
// {c_out,sum} = a + b + c_in.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic c_out,
    output logic sum
);

    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {1'b0, c_in};

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder driving a single fa_cell, LSB first.
// One add per WIDTH+2 cycles; result registers hold until next completion.
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out
);

    localparam int CW = cnt_width(WIDTH);

    if (WIDTH < 2 || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_adder: WIDTH out of range");
    end

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_nx;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             cell_s;
    logic             cell_c;
    logic             accept;
    logic             shifting;
    logic             last;

    fa_cell u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c_in  (carry),
        .c_out (cell_c),
        .sum   (cell_s)
    );

    // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts
    assign res_nx = (res_sh >> 1) | (WIDTH'(cell_s) << (WIDTH - 1));

    always_comb begin
        state_nx = IDLE;
        accept   = 1'b0;
        shifting = 1'b0;
        last     = 1'b0;
        case (state)
            SHIFT: begin
                shifting = 1'b1;
                last     = (cnt == CW'(WIDTH - 1));
                state_nx = last ? DONE : SHIFT;
            end
            DONE: state_nx = IDLE;
            default: begin
                accept   = start;
                state_nx = start ? SHIFT : IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum_out <= '0;
            c_out   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_sh  <= a_in;
                b_sh  <= b_in;
                carry <= c_in;
                cnt   <= '0;
            end else if (shifting) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                res_sh <= res_nx;
                carry  <= cell_c;
                // Hold on the final bit so the counter never wraps
                if (!last) begin
                    cnt <= cnt + CW'(1);
                end else begin
                    sum_out <= res_nx;
                    c_out   <= cell_c;
                end
            end
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=32.
// Directed table, multi-cycle corner sequences and random adds.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        c8 = 1'b0;
    logic        busy8;
    logic        done8;
    logic [7:0]  sum8;
    logic        cout8;

    logic        start32 = 1'b0;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic        c32 = 1'b0;
    logic        busy32;
    logic        done32;
    logic [31:0] sum32;
    logic        cout32;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start8),
        .a_in    (a8),
        .b_in    (b8),
        .c_in    (c8),
        .busy    (busy8),
        .done    (done8),
        .sum_out (sum8),
        .c_out   (cout8)
    );

    serial_adder #(.WIDTH(32)) dut32 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start32),
        .a_in    (a32),
        .b_in    (b32),
        .c_in    (c32),
        .busy    (busy32),
        .done    (done32),
        .sum_out (sum32),
        .c_out   (cout32)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] s;
        logic       co;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns after the DONE cycle has passed, with the block back in IDLE
    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic c, input bit scramble,
                       output logic [8:0] res, output int lat,
                       output bit busy_ok, output logic dn_after);
        a8 = a;
        b8 = b;
        c8 = c;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (!done8 && lat < 40) begin
            busy_ok &= busy8;
            if (scramble) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                c8 = 1'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        res = {cout8, sum8};
        @(posedge clk);
        #1;
        dn_after = done8;
    endtask

    task automatic op32(input logic [31:0] a, input logic [31:0] b,
                        input logic c, output logic [32:0] res,
                        output int lat);
        a32 = a;
        b32 = b;
        c32 = c;
        start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        lat = 0;
        while (!done32 && lat < 80) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = {cout32, sum32};
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        vecs [7];
        logic [8:0]  r8;
        logic [32:0] r32;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        int          lat;
        bit          bok;
        logic        dn;

        vecs[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[6] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};

        #2;
        chk("reset8", {busy8, done8, cout8, sum8}, '0);
        chk("reset32", {busy32, done32, cout32, sum32}, '0);
        @(posedge clk);
        #1;
        chk("reset8_clk", {busy8, done8, cout8, sum8}, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].c, 1'b0, r8, lat, bok, dn);
            chk("vec_result", r8, {vecs[i].co, vecs[i].s});
            chk("vec_latency", lat, 8);
            chk("vec_busy", bok, 1);
            chk("vec_done_pulse", dn, 0);
        end

        // Operands toggle every SHIFT cycle; result must follow the captured ones
        op8(8'h00, 8'h00, 1'b1, 1'b1, r8, lat, bok, dn);
        chk("scramble_result", r8, 9'h001);
        chk("scramble_latency", lat, 8);
        op8(8'h3C, 8'h05, 1'b0, 1'b1, r8, lat, bok, dn);
        chk("scramble2_result", r8, 9'h041);

        // Result holds across idle cycles
        a8 = 8'hEE;
        b8 = 8'h11;
        repeat (3) @(posedge clk);
        #1;
        chk("hold_idle", {busy8, done8, cout8, sum8}, {2'b00, 9'h041});

        // start held high: accepts every WIDTH+2 edges, one done per op
        a8 = 8'h3C;
        b8 = 8'h05;
        c8 = 1'b0;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 30; k++) begin
            chk("hold_start", {busy8, done8}, {(k % 10) <= 7, (k % 10) == 8});
            @(posedge clk);
            #1;
        end
        start8 = 1'b0;
        for (int k = 0; k < 20 && (busy8 || done8); k++) begin
            @(posedge clk);
            #1;
        end
        chk("hold_start_drain", {busy8, done8}, 2'b00);
        chk("hold_start_result", {cout8, sum8}, 9'h041);

        // Asynchronous reset mid-SHIFT
        a8 = 8'hFF;
        b8 = 8'h01;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_reset_busy", busy8, 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset", {busy8, done8, cout8, sum8}, '0);
        @(posedge clk);
        #1;
        chk("reset_hold", {busy8, done8, cout8, sum8}, '0);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            chk("post_reset_idle", {busy8, done8}, 2'b00);
        end
        op8(8'h12, 8'h34, 1'b0, 1'b0, r8, lat, bok, dn);
        chk("post_reset_add", r8, 9'h046);
        chk("post_reset_lat", lat, 8);

        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom);
            op8(ra[7:0], rb[7:0], rc, 1'b0, r8, lat, bok, dn);
            chk("rand8", r8, {1'b0, ra[7:0]} + {1'b0, rb[7:0]} + 9'(rc));
            chk("rand8_lat", lat, 8);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom);
            op32(ra, rb, rc, r32, lat);
            chk("rand32", r32, {1'b0, ra} + {1'b0, rb} + 33'(rc));
            chk("rand32_lat", lat, 32);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        op32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, r32, lat);
        chk("carry_chain32", r32, 33'h1_0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around a single 1-bit full-adder cell.
- Captures two WIDTH-bit operands and a carry-in on a start pulse.
- Each clock it feeds one operand bit pair plus the registered carry into the cell, and collects the sum bit and carry-out.
- Used where area matters more than latency. It is the sequential driver/consumer stage for the 1-bit full-adder cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a_in  input  WIDTH  operand A; captured on an accepted start
- b_in  input  WIDTH  operand B; captured on an accepted start
- c_in  input  1  carry-in; captured on an accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse: result valid
- sum_out  output  WIDTH  registered sum
- c_out  output  1  registered final carry-out

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, takes effect immediately, independent of clk):
  - state=IDLE; busy=0, done=0, sum_out=0, c_out=0.
  - Internal shift registers, carry register and bit counter = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1 at a clock edge: load a_sh<=a_in, b_sh<=b_in, carry<=c_in, cnt<=0, then go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - Cell inputs are a_sh[0], b_sh[0] and carry.
  - Each edge: a_sh and b_sh shift right by 1; the cell sum bit enters res_sh[WIDTH-1] as res_sh shifts right; carry<=cell c_out; cnt<=cnt+1.
  - When cnt==WIDTH-1 at an edge, that edge also loads sum_out<=final res_sh value (including the bit just produced), loads c_out<=cell carry, and moves to DONE.
- DONE:
  - done=1 for exactly one cycle, then unconditionally back to IDLE.
- busy = (state==SHIFT). done = (state==DONE). Both are decoded from registered state, so they are glitch-free.
- Latency and throughput:
  - Start is sampled at edge E0; done is high after edge E0+WIDTH.
  - Next start is accepted no earlier than edge E0+WIDTH+2.
  - Throughput is one add per WIDTH+2 cycles.
- start while busy or in DONE is ignored. No queuing, no error flag.
- a_in, b_in and c_in are don't-care except on the accepting edge. Later changes must not affect an operation in progress.
- sum_out and c_out change only on the SHIFT->DONE edge and otherwise hold. The previous result stays readable until the next completion.
- Arithmetic: {c_out,sum_out} = a_in + b_in + c_in, computed modulo 2^(WIDTH+1). There is no overflow/signed flag; c_out is the unsigned carry.
- cnt is ceil(log2(WIDTH)) bits wide and never wraps: it is cleared on accept.
- Reset asserted mid-SHIFT aborts the operation: no done pulse, outputs go to 0. After release the block idles until a new start.

Decomposition:
- Shared package serial_arith_pkg holds:
  - state enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2; 2'd3 decodes to IDLE)
  - WIDTH_MAX=32 constant
  - counter-width function.
- One sub-module, instantiated once: fa_cell, a purely combinational 1-bit full adder (a, b, c_in -> c_out, sum) computing {c_out,sum}=a+b+c_in.
- FSM, counter and shift registers stay in serial_adder.

Test Plan:
1. WIDTH=8: a=8'h3C, b=8'h05, c_in=0, start at E0 -> busy high for cycles 1..8; done pulse after E0+8; sum_out=8'h41, c_out=0.
2. a=8'hFF, b=8'h01, c_in=0 -> sum_out=8'h00, c_out=1. Repeat with a=8'hFF, b=8'hFF, c_in=1 -> sum_out=8'hFF, c_out=1 (full carry chain).
3. a=8'h00, b=8'h00, c_in=1 -> sum_out=8'h01, c_out=0. Then change a_in/b_in every cycle during SHIFT -> result unchanged.
4. start held high continuously -> accepts at E0, E0+10, E0+20. Exactly one done per op; start during busy/DONE is ignored.
5. Assert rst_n low at cycle 4 of SHIFT -> outputs 0 immediately without waiting for clk; no done. After release, idle until start; a new add (8'h12+8'h34 -> 8'h46) completes correctly.
6. Random self-check, 1000 ops each at WIDTH=8 and WIDTH=32, with random start gaps -> {c_out,sum_out} matches a+b+c_in every time.
